// File: rtl/arith_nibble_sequencer_pkg.sv
// Shared definitions for the nibble-serial arithmetic sequencer: op codes,
// FSM state encoding and the carry injected into the first nibble.
package arith_nibble_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_INC = 2'b10,
    OP_DEC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Sub and inc need +1 at the bottom (two's complement / increment);
  // dec relies on adding all-ones with no carry.
  function automatic logic first_carry(input logic [1:0] op, input logic carry_in);
    logic c;
    case (op)
      OP_ADD:         c = carry_in;
      OP_SUB, OP_INC: c = 1'b1;
      default:        c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/arith_nibble_sequencer.sv
// Drives an external 4-bit add/sub/inc/dec unit across WIDTH/4 nibbles,
// LSB first, chaining the carry through a register to build WIDTH-bit results.
module arith_nibble_sequencer
  import arith_nibble_sequencer_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NIBBLES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic [3:0]       au_a,
  output logic [3:0]       au_b,
  output logic             au_cin,
  output logic [1:0]       au_s,
  input  logic [3:0]       au_d,
  input  logic             au_cout
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  // Handshake: start is accepted only in IDLE (single-cycle pulse is enough);
  // busy covers RUN and DONE, and done pulses for one cycle with result/c_out
  // valid, which then hold until the next accepted start.

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [1:0]         op_q;
  logic               cin0_q;
  logic               carry_q;
  logic [WIDTH-1:0]   result_q;
  logic               c_out_q;

  logic [WIDTH-1:0]   a_sh, b_sh;
  logic               last;

  assign a_sh = a_q >> {idx_q, 2'b00};
  assign b_sh = b_q >> {idx_q, 2'b00};
  assign last = (idx_q == IDX_W'(NIBBLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    au_a    = 4'h0;
    au_b    = 4'h0;
    au_cin  = 1'b0;
    au_s    = 2'b00;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        au_a   = a_sh[3:0];
        au_b   = b_sh[3:0];
        au_s   = op_q;
        au_cin = (idx_q == '0) ? cin0_q : carry_q;
        if (last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 2'b00;
      cin0_q   <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      c_out_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            op_q   <= op;
            cin0_q <= first_carry(op, carry_in);
            idx_q  <= '0;
          end
        end
        ST_RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == IDX_W'(n)) result_q[4*n +: 4] <= au_d;
          end
          carry_q <= au_cout;
          if (last) begin
            c_out_q <= au_cout;
            idx_q   <= '0;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign c_out  = c_out_q;

endmodule

// File: doc/arith_nibble_sequencer.md
Name: arith_nibble_sequencer

Overview:
- Sequences one shared 4-bit arithmetic unit (add / subtract / increment / decrement, selected by S1:S0) over WIDTH/4 nibbles, LSB nibble first.
- Chains the nibble carry through an internal register, giving WIDTH-bit results from the 4-bit datapath.
- Sits between a requester (start/done handshake) and the arithmetic unit, which is instantiated at the level above and connected through the au_* ports.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived nibble count; not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  00 add, 01 sub, 10 inc, 11 dec (same encoding as the unit's S1:S0).
- carry_in  input  1  carry into nibble 0 for add; ignored for the other ops.
- a  input  WIDTH  operand A; captured on start.
- b  input  WIDTH  operand B; captured on start, unused for inc/dec.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse, result valid.
- result  output  WIDTH  final result; held until the next accepted start.
- c_out  output  1  carry out of the top nibble; held with result.
- au_a  output  4  nibble of A to the unit.
- au_b  output  4  nibble of B to the unit.
- au_cin  output  1  carry into the unit.
- au_s  output  2  unit operation select {S1,S0}.
- au_d  input  4  unit sum nibble (combinational from au_*).
- au_cout  input  1  unit carry out.

Behaviour:
- Reset (rst_n=0 at a clock edge) applies from any state, including mid-RUN; the in-flight operation is discarded with no done pulse.
  - State returns to IDLE; busy, done, result, c_out, the nibble index, the carry register and the captured operands all clear to 0.
  - au_a, au_b, au_cin and au_s read 0 while in IDLE.
- States and transitions:
  - IDLE → RUN on start=1. Capture a, b and op, plus cin0 = carry_in (add), 1 (sub), 1 (inc), 0 (dec). Set idx=0.
  - RUN lasts exactly NIBBLES cycles. Each cycle:
    - au_a = A_cap[4*idx+3:4*idx], au_b = B_cap nibble idx, au_s = op_cap.
    - au_cin = cin0 when idx=0, otherwise carry_reg.
    - At the edge: result nibble idx <= au_d, carry_reg <= au_cout, idx <= idx+1.
    - On the edge where idx=NIBBLES-1: c_out <= au_cout, then go to DONE.
  - DONE lasts one cycle: done=1, busy=1, then → IDLE.
- Latency: start sampled at edge T puts done high in the cycle after edge T+NIBBLES.
  - Example for WIDTH=8: accept at edge 0, RUN cycles 1–2, done in cycle 3.
  - Back-to-back throughput is one operation per NIBBLES+2 cycles.
- start is ignored in RUN and DONE: no queueing, and captured operands are not disturbed. a, b, op and carry_in may change freely after acceptance.
- Arithmetic: result = (A op B) mod 2^WIDTH.
  - Sub is A + ~B + 1; c_out=1 means no borrow.
  - Inc is A + 0 + 1; c_out=1 only when A is all ones.
  - Dec is A + all-ones + 0; c_out=0 only when A=0.
- result and c_out update progressively during RUN. They are valid only from the done cycle and stay stable until the next accepted start.
- WIDTH=4 gives a single RUN cycle.
- The nibble index width is clog2(NIBBLES), minimum 1 bit.

Decomposition:
- Shared package holds:
  - Op codes: OP_ADD=2'b00, OP_SUB=2'b01, OP_INC=2'b10, OP_DEC=2'b11.
  - State encoding: ST_IDLE, ST_RUN, ST_DONE.
  - The first-nibble carry function of op and carry_in.
- No sub-module inside this block. The arithmetic unit stays external so it can be arbitrated or shared at the top level.
- The bench wires one unit instance to the au_* ports.

Test Plan:
- WIDTH=8, add: a=0x55, b=0x33, carry_in=0 → result=0x88, c_out=0, done 3 cycles after acceptance; repeat with carry_in=1 → 0x89, c_out=0.
- Sub and carry chaining: a=0x55, b=0x33, op=01 → 0x22, c_out=1. a=0x10, b=0x01 → 0x0F, c_out=1 (carry crosses the nibble boundary). a=0x33, b=0x55 → 0xDE, c_out=0.
- Inc/dec wrap: inc a=0xFF → 0x00, c_out=1. dec a=0x00 → 0xFF, c_out=0. dec a=0x55 → 0x54, c_out=1.
- Handshake: pulse start with a=0x01, b=0x01, add, then pulse start again during RUN and during DONE with a=0xAA → exactly one done, result=0x02, busy high for 3 cycles, and result holds 0x02 until the next start in IDLE.
- Reset mid-operation: drive rst_n=0 on the cycle after acceptance → next cycle IDLE, busy=0, result=0x00, c_out=0, no done. A following add 0x0F+0x01 gives 0x10.
- WIDTH=16 sweep: 256 random operand/op pairs checked against a reference model; done at exactly NIBBLES+1=5 cycles after acceptance.
